// File: rtl/rtc_access_scheduler.sv
// RTC bus scheduler: refresh sweeps into local memory plus
// translated user writes, with bus timeout handling.
module rtc_access_scheduler #(
  parameter logic [7:0]  LATCH_ADDR  = 8'hF0,
  parameter logic [7:0]  LATCH_DATA  = 8'h00,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_refresh,
  input  logic       wr_req,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       bus_start,
  output logic       bus_rw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  input  logic [7:0] bus_rdata,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       sweep_done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, LATCH, LATCH_WAIT, RD_ISSUE,
    RD_WAIT, WR_ISSUE, WR_WAIT, SWEEP_END
  } state_t;

  localparam logic [8:0] TMO = 9'(TIMEOUT_CYC);

  state_t     state, state_nx;
  logic       pend;
  logic [3:0] idx;
  logic [7:0] tcnt;
  logic       wr_valid, wr_bad, tmo, go_latch;

  function automatic logic [7:0] idx2addr(input logic [3:0] i);
    if (i < 4'd7) return 8'h21 + {4'd0, i};
    else          return 8'h41 + {4'd0, i} - 8'd7;
  endfunction

  // A request still high while its ack is out is already served.
  assign wr_valid = wr_req && !wr_ack;
  assign wr_bad   = wr_valid && (wr_idx > 4'd9);
  // tcnt counts cycles since bus_start.
  assign tmo      = ({1'b0, tcnt} + 9'd1) >= TMO;
  assign go_latch = (state == IDLE) && (state_nx == LATCH);

  assign bus_start  = (state == LATCH) || (state == RD_ISSUE) ||
                      (state == WR_ISSUE);
  assign busy       = (state != IDLE);
  assign sweep_done = (state == SWEEP_END);

  // Next-state: arbitration, bus completion and timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wr_valid && !wr_bad) state_nx = WR_ISSUE;
        else if (!wr_valid && pend) state_nx = LATCH;
      end
      LATCH:      state_nx = LATCH_WAIT;
      LATCH_WAIT: begin
        if (bus_done) state_nx = RD_ISSUE;
        else if (tmo) state_nx = IDLE;
      end
      RD_ISSUE:   state_nx = RD_WAIT;
      RD_WAIT: begin
        if (bus_done)
          state_nx = (idx == 4'd9) ? SWEEP_END : RD_ISSUE;
        else if (tmo) state_nx = IDLE;
      end
      WR_ISSUE:   state_nx = WR_WAIT;
      WR_WAIT: begin
        if (bus_done || tmo) state_nx = IDLE;
      end
      SWEEP_END:  state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // State, datapath registers and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= 1'b0;
      idx       <= 4'd0;
      tcnt      <= 8'd0;
      wr_ack    <= 1'b0;
      err       <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= 8'd0;
      bus_wdata <= 8'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 4'd0;
      mem_wdata <= 8'd0;
    end else begin
      state  <= state_nx;
      wr_ack <= 1'b0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      if (go_latch) pend <= 1'b0;
      else if (tick_refresh) pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (wr_bad) begin
            wr_ack <= 1'b1;
            err    <= 1'b1;
          end else if (state_nx == WR_ISSUE) begin
            bus_rw    <= 1'b0;
            bus_addr  <= idx2addr(wr_idx);
            bus_wdata <= wr_data;
          end else if (state_nx == LATCH) begin
            bus_rw    <= 1'b0;
            bus_addr  <= LATCH_ADDR;
            bus_wdata <= LATCH_DATA;
          end
        end
        LATCH, RD_ISSUE, WR_ISSUE: tcnt <= 8'd1;
        LATCH_WAIT: begin
          if (bus_done) begin
            idx      <= 4'd0;
            bus_rw   <= 1'b1;
            bus_addr <= idx2addr(4'd0);
          end else begin
            tcnt <= tcnt + 8'd1;
            if (tmo) err <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (bus_done) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx;
            mem_wdata <= bus_rdata;
            if (idx != 4'd9) begin
              idx      <= idx + 4'd1;
              bus_addr <= idx2addr(idx + 4'd1);
            end
          end else begin
            tcnt <= tcnt + 8'd1;
            if (tmo) err <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (bus_done) wr_ack <= 1'b1;
          else begin
            tcnt <= tcnt + 8'd1;
            if (tmo) begin
              err    <= 1'b1;
              wr_ack <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
